// File: rtl/matrix_stream_loader_pkg.sv
// matrix_stream_loader_pkg
// Shared definitions for the systolic-array host front end: the loader FSM
// state encoding, default buffer geometry, and the stream word/flag types
// that the loader and the array top both use.
package matrix_stream_loader_pkg;

  localparam int DEF_SIZE    = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int FRAME_WORDS = 3 * DEF_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_LOAD_I,
    ST_START,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  typedef logic [DEF_DATA_W-1:0] stream_word_t;

  typedef struct packed {
    logic valid;
    logic last;
  } stream_flags_t;

  // Input words per job for a given buffer depth (A, B and I back to back).
  function automatic int frame_words(input int size);
    return 3 * size;
  endfunction

endpackage

// File: rtl/result_skid_fifo.sv
// result_skid_fifo
// Two-entry FIFO carrying a data word plus its last flag. Occupancy is
// exported so an upstream stage can meter reads against free space.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (flushes contents)
//   push       : write push_data this cycle (caller guarantees not full)
//   push_data  : {last, data}
//   pop        : consume head this cycle (caller guarantees valid)
//   head       : {last, data} of the oldest entry
//   valid      : FIFO holds at least one entry
//   count      : occupancy 0..2
module result_skid_fifo #(
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [DATA_W:0] push_data,
  input  logic            pop,
  output logic [DATA_W:0] head,
  output logic            valid,
  output logic [1:0]      count
);

  logic [DATA_W:0] mem [0:1];
  logic            wr_ptr;
  logic            rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader
// Host-side front end for the systolic array. Streams one frame of 3*SIZE
// words into the A, B and I operand buffers, pulses ap_start, waits for
// ap_done, then reads SIZE result words and emits them as a stream with last.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   s_valid/s_ready/s_data/s_last : input word stream
//   m_valid/m_ready/m_data/m_last : result word stream
//   addrA/enA/dataA (B, I)   : registered operand buffer write ports
//   addrO/dataO              : result read port, dataO one cycle after addrO
//   ap_start/ap_done         : compute handshake
//   busy                     : high whenever the FSM is not IDLE
//   frame_err                : sticky, s_last seen on the wrong word
//   perf_cycles              : WAIT-cycle counter, only with LOADER_PERF_EN
module matrix_stream_loader
  import matrix_stream_loader_pkg::*;
#(
  parameter int SIZE   = DEF_SIZE,
  parameter int ADDR_W = $clog2(SIZE),
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [ADDR_W-1:0] addrA,
  output logic              enA,
  output logic [DATA_W-1:0] dataA,
  output logic [ADDR_W-1:0] addrB,
  output logic              enB,
  output logic [DATA_W-1:0] dataB,
  output logic [ADDR_W-1:0] addrI,
  output logic              enI,
  output logic [DATA_W-1:0] dataI,
  output logic [ADDR_W-1:0] addrO,
  input  logic [DATA_W-1:0] dataO,
  output logic              ap_start,
  input  logic              ap_done,
  output logic              busy,
  output logic              frame_err
`ifdef LOADER_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(SIZE - 1);
  localparam logic [ADDR_W:0]   RD_END  = (ADDR_W + 1)'(SIZE);
  localparam logic [ADDR_W:0]   RD_LAST = (ADDR_W + 1)'(SIZE - 1);

  state_t            state;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W-1:0] addr_hold;
  logic              vld_p1;
  logic              last_p1;

  logic              s_hs;
  logic              final_word;
  logic              pop;
  logic              issue;
  logic [2:0]        credit;
  logic [1:0]        fifo_count;
  logic              fifo_valid;
  logic [DATA_W:0]   fifo_head;

  assign s_ready    = (state == ST_IDLE) || (state == ST_LOAD_A) ||
                      (state == ST_LOAD_B) || (state == ST_LOAD_I);
  assign busy       = (state != ST_IDLE);
  assign s_hs       = s_valid && s_ready;
  assign final_word = (state == ST_LOAD_I) && (k == K_LAST);

  // Credit covers the word sitting on dataO; a same-cycle pop frees a slot,
  // which is what lets the drain sustain one word per cycle with two entries.
  assign pop    = m_valid && m_ready;
  assign credit = {1'b0, fifo_count} + {2'b0, vld_p1};
  assign issue  = (state == ST_DRAIN) && (rd_cnt != RD_END) &&
                  (credit < (3'd2 + {2'b0, pop}));
  assign addrO  = issue ? rd_cnt[ADDR_W-1:0] : addr_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      k         <= '0;
      rd_cnt    <= '0;
      addr_hold <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      enA       <= 1'b0;
      enB       <= 1'b0;
      enI       <= 1'b0;
      addrA     <= '0;
      addrB     <= '0;
      addrI     <= '0;
      dataA     <= '0;
      dataB     <= '0;
      dataI     <= '0;
      ap_start  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      enA      <= 1'b0;
      enB      <= 1'b0;
      enI      <= 1'b0;
      ap_start <= 1'b0;

      // p0 -> p1: address presented this cycle, data appears on dataO next
      vld_p1  <= issue;
      last_p1 <= issue && (rd_cnt == RD_LAST);
      if (issue) begin
        addr_hold <= rd_cnt[ADDR_W-1:0];
        rd_cnt    <= rd_cnt + 1'b1;
      end

      if (s_hs && (s_last != final_word)) frame_err <= 1'b1;

      case (state)
        ST_IDLE, ST_LOAD_A: begin
          if (s_hs) begin
            enA   <= 1'b1;
            addrA <= k;
            dataA <= s_data;
            if (k == K_LAST) begin
              k     <= '0;
              state <= ST_LOAD_B;
            end else begin
              k     <= k + 1'b1;
              state <= ST_LOAD_A;
            end
          end
        end
        ST_LOAD_B: begin
          if (s_hs) begin
            enB   <= 1'b1;
            addrB <= k;
            dataB <= s_data;
            if (k == K_LAST) begin
              k     <= '0;
              state <= ST_LOAD_I;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        ST_LOAD_I: begin
          if (s_hs) begin
            enI   <= 1'b1;
            addrI <= k;
            dataI <= s_data;
            if (k == K_LAST) begin
              k     <= '0;
              state <= ST_START;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        ST_START: begin
          ap_start <= 1'b1;
          rd_cnt   <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ap_done) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && m_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // p1 -> FIFO: capture the read data together with its last flag
  result_skid_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (vld_p1),
    .push_data({last_p1, dataO}),
    .pop      (pop),
    .head     (fifo_head),
    .valid    (fifo_valid),
    .count    (fifo_count)
  );

  assign m_valid = fifo_valid;
  assign m_data  = fifo_valid ? fifo_head[DATA_W-1:0] : '0;
  assign m_last  = fifo_valid && fifo_head[DATA_W];

`ifdef LOADER_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Counts WAIT cycles until ap_done; holds its value until the next START.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= 32'd0;
    end else if (state == ST_START) begin
      perf_cycles <= 32'd0;
    end else if ((state == ST_WAIT) && !ap_done) begin
      perf_cycles <= sat_inc32(perf_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_matrix_stream_loader.sv
module tb_matrix_stream_loader;

  localparam int SIZE   = 4;
  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [ADDR_W-1:0] addrA, addrB, addrI, addrO;
  logic              enA, enB, enI;
  logic [DATA_W-1:0] dataA, dataB, dataI;
  logic [DATA_W-1:0] dataO = '0;
  logic              ap_start;
  logic              ap_done = 1'b0;
  logic              busy;
  logic              frame_err;
`ifdef LOADER_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side view of the buffers and strobe history
  int memA [0:SIZE-1];
  int memB [0:SIZE-1];
  int memI [0:SIZE-1];
  int wr_cnt    = 0;
  int start_cnt = 0;
  int cyc       = 0;
  int last_eni  = 0;
  int start_cyc = 0;
  int wr0       = 0;
  int st0       = 0;

  always #5 clk = ~clk;

  matrix_stream_loader #(
    .SIZE  (SIZE),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .addrA    (addrA),
    .enA      (enA),
    .dataA    (dataA),
    .addrB    (addrB),
    .enB      (enB),
    .dataB    (dataB),
    .addrI    (addrI),
    .enI      (enI),
    .dataI    (dataI),
    .addrO    (addrO),
    .dataO    (dataO),
    .ap_start (ap_start),
    .ap_done  (ap_done),
    .busy     (busy),
    .frame_err(frame_err)
`ifdef LOADER_PERF_EN
    ,
    .perf_cycles(perf_cycles)
`endif
  );

  // Result memory model: registered read, contents = address + 100
  always @(posedge clk) dataO <= {{(DATA_W-ADDR_W){1'b0}}, addrO} + DATA_W'(100);

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (enA) begin memA[addrA] <= int'(dataA); end
    if (enB) begin memB[addrB] <= int'(dataB); end
    if (enI) begin memI[addrI] <= int'(dataI); last_eni <= cyc + 1; end
    if (enA || enB || enI) wr_cnt <= wr_cnt + ((enA ? 1 : 0) + (enB ? 1 : 0) + (enI ? 1 : 0));
    if (ap_start) begin start_cnt <= start_cnt + 1; start_cyc <= cyc + 1; end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_frame(input int base, input int last_pos);
    for (int i = 0; i < 3*SIZE; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = DATA_W'(base + i);
      s_last  = (i == last_pos);
      #1;
      n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready word=%0d got=%0b exp=1", i, s_ready); end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    #1;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL start_ready got=%0b exp=0", s_ready); end
  endtask

  task automatic wait_start;
    bit found;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk); #1;
      if (ap_start === 1'b1) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL ap_start_seen got=0 exp=1"); end
    n_checks++; if (start_cyc - last_eni != 1) begin n_fail++; $display("FAIL start_after_eni got=%0d exp=1", start_cyc - last_eni); end
  endtask

  task automatic check_buffers(input int base);
    for (int i = 0; i < SIZE; i++) begin
      n_checks++; if (memA[i] != base + i) begin n_fail++; $display("FAIL bufA[%0d] got=%0d exp=%0d", i, memA[i], base + i); end
      n_checks++; if (memB[i] != base + SIZE + i) begin n_fail++; $display("FAIL bufB[%0d] got=%0d exp=%0d", i, memB[i], base + SIZE + i); end
      n_checks++; if (memI[i] != base + 2*SIZE + i) begin n_fail++; $display("FAIL bufI[%0d] got=%0d exp=%0d", i, memI[i], base + 2*SIZE + i); end
    end
  endtask

  // Entered in the first WAIT cycle; ap_done stays low for 'hold' WAIT cycles
  // then pulses; returns at the negedge of the first DRAIN cycle.
  task automatic pulse_done(input int hold);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk); ap_done = 1'b0;
    end
    @(negedge clk); ap_done = 1'b1;
    @(negedge clk); ap_done = 1'b0;
  endtask

  // Called from the first DRAIN cycle. bp selects the 1,0,0 m_ready pattern;
  // tp checks that word i is accepted exactly 2+i cycles into DRAIN.
  task automatic drain(input bit bp, input bit tp);
    int acc;
    bit held_v;
    logic [DATA_W-1:0] held;
    acc = 0; held_v = 1'b0; held = '0;
    for (int c = 0; c < 40 && acc < SIZE; c++) begin
      if (c > 0) @(negedge clk);
      m_ready = bp ? (c % 3 == 0) : 1'b1;
      #1;
      n_checks++; if (int'(addrO) > acc + 2) begin n_fail++; $display("FAIL addr_ahead got=%0d exp<=%0d", addrO, acc + 2); end
      if (held_v) begin
        n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL valid_drop got=%0b exp=1", m_valid); end
        n_checks++; if (m_data !== held) begin n_fail++; $display("FAIL head_stable got=%0d exp=%0d", m_data, held); end
      end
      if (m_valid && m_ready) begin
        n_checks++; if (m_data !== DATA_W'(100 + acc)) begin n_fail++; $display("FAIL drain_data got=%0d exp=%0d", m_data, 100 + acc); end
        n_checks++; if (m_last !== (acc == SIZE-1)) begin n_fail++; $display("FAIL drain_last word=%0d got=%0b", acc, m_last); end
        if (tp) begin
          n_checks++; if (c != 2 + acc) begin n_fail++; $display("FAIL drain_timing word=%0d got_cycle=%0d exp=%0d", acc, c, 2 + acc); end
        end
        acc++;
        held_v = 1'b0;
      end else if (m_valid) begin
        held_v = 1'b1;
        held   = m_data;
      end
    end
    n_checks++; if (acc != SIZE) begin n_fail++; $display("FAIL drain_count got=%0d exp=%0d", acc, SIZE); end
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_drain got=%0b exp=0", busy); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL valid_after_drain got=%0b exp=0", m_valid); end
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_drain got=%0b exp=1", s_ready); end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_checks++; if ({enA, enB, enI} !== 3'b000) begin n_fail++; $display("FAIL reset_en got=%b exp=000", {enA, enB, enI}); end
    n_checks++; if ({addrA, addrB, addrI, addrO} !== '0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", {addrA, addrB, addrI, addrO}); end
    n_checks++; if ({dataA, dataB, dataI} !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", {dataA, dataB, dataI}); end
    n_checks++; if ({ap_start, m_valid, m_last, frame_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=0000", {ap_start, m_valid, m_last, frame_err}); end
    rst = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got=%0b exp=1", s_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_frame_load;
    wr0 = wr_cnt;
    st0 = start_cnt;
    load_frame(0, 3*SIZE-1);
    wait_start();
    check_buffers(0);
    n_checks++; if (wr_cnt - wr0 != 3*SIZE) begin n_fail++; $display("FAIL write_count got=%0d exp=%0d", wr_cnt - wr0, 3*SIZE); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL clean_frame_err got=%0b exp=0", frame_err); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy got=%0b exp=1", busy); end
  endtask

  task automatic test_compute_wait;
    m_ready = 1'b1;
    pulse_done(20);
    #1;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL drain_s_ready got=%0b exp=0", s_ready); end
    n_checks++; if (start_cnt - st0 != 1) begin n_fail++; $display("FAIL start_pulses got=%0d exp=1", start_cnt - st0); end
`ifdef LOADER_PERF_EN
    n_checks++; if (perf_cycles !== 32'd20) begin n_fail++; $display("FAIL perf_cycles got=%0d exp=20", perf_cycles); end
`endif
  endtask

  task automatic test_drain_throughput;
    drain(1'b0, 1'b1);
`ifdef LOADER_PERF_EN
    n_checks++; if (perf_cycles !== 32'd20) begin n_fail++; $display("FAIL perf_frozen got=%0d exp=20", perf_cycles); end
`endif
  endtask

  task automatic test_backpressure;
    load_frame(20, 3*SIZE-1);
    wait_start();
    check_buffers(20);
    pulse_done(2);
    drain(1'b1, 1'b0);
  endtask

  task automatic test_framing_error;
    wr0 = wr_cnt;
    load_frame(40, 5);
    wait_start();
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_err_set got=%0b exp=1", frame_err); end
    n_checks++; if (wr_cnt - wr0 != 3*SIZE) begin n_fail++; $display("FAIL err_write_count got=%0d exp=%0d", wr_cnt - wr0, 3*SIZE); end
    check_buffers(40);
    pulse_done(3);
    drain(1'b0, 1'b1);
    load_frame(60, 3*SIZE-1);
    wait_start();
    check_buffers(60);
    pulse_done(1);
    drain(1'b0, 1'b1);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL frame_err_sticky got=%0b exp=1", frame_err); end
  endtask

  task automatic test_async_reset;
    bit seen;
    load_frame(80, 3*SIZE-1);
    wait_start();
    pulse_done(2);
    m_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk); #1;
      if (m_valid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL pre_reset_valid got=0 exp=1"); end
    #3 rst = 1'b1;
    #1;
    n_checks++; if ({m_valid, m_last, ap_start} !== 3'b000) begin n_fail++; $display("FAIL async_rst_out got=%b exp=000", {m_valid, m_last, ap_start}); end
    n_checks++; if ({enA, enB, enI} !== 3'b000) begin n_fail++; $display("FAIL async_rst_en got=%b exp=000", {enA, enB, enI}); end
    n_checks++; if ({busy, frame_err} !== 2'b00) begin n_fail++; $display("FAIL async_rst_state got=%b exp=00", {busy, frame_err}); end
    #7 rst = 1'b0;
    m_ready = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready got=%0b exp=1", s_ready); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid got=%0b exp=0", m_valid); end
    load_frame(120, 3*SIZE-1);
    wait_start();
    check_buffers(120);
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL post_rst_frame_err got=%0b exp=0", frame_err); end
    pulse_done(2);
    drain(1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_frame_load();
    test_compute_wait();
    test_drain_throughput();
    test_backpressure();
    test_framing_error();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
